// File: rtl/xor_descrambler.sv
// Self-synchronizing x^7 + x^6 + 1 descrambler for a serial valid/ready bit stream.
// Drops the 7 flush bits, packs recovered bits LSB-first into WIDTH-bit words behind a one-word output register.
module xor_descrambler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             locked
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    FLUSH,
    LOCKED
  } state_t;

  state_t           state;
  logic [6:0]       sr;
  logic [2:0]       flush_cnt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] asm_word;
  logic [WIDTH-1:0] word;
  logic             d;
  logic             last_bit;
  logic             xfer;
  logic             word_done;

  assign d         = in_bit ^ sr[6] ^ sr[5];
  assign locked    = (state == LOCKED);
  assign last_bit  = (bit_cnt == LAST);
  // Only the word-completing bit waits on a full output register.
  assign in_ready  = !clear && !(locked && last_bit && out_valid && !out_ready);
  assign xfer      = in_valid && in_ready;
  assign word_done = xfer && locked && last_bit;

  always_comb begin
    word          = asm_word;
    word[bit_cnt] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FLUSH;
      sr        <= '0;
      flush_cnt <= '0;
      bit_cnt   <= '0;
      asm_word  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      state     <= FLUSH;
      sr        <= '0;
      flush_cnt <= '0;
      bit_cnt   <= '0;
      asm_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (word_done) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end
      if (xfer) begin
        sr <= {sr[5:0], in_bit};
        case (state)
          FLUSH: begin
            if (flush_cnt == 3'd6) begin
              state     <= LOCKED;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + 3'd1;
            end
          end
          LOCKED: begin
            asm_word[bit_cnt] <= d;
            bit_cnt           <= last_bit ? '0 : bit_cnt + 1'b1;
          end
          default: state <= FLUSH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler: lock pattern, scrambled round trip, backpressure, clear and async reset.
module tb_xor_descrambler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       locked;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stalls = 0;
  int unsigned cyc = 0;
  logic [6:0]  st;
  logic [31:0] capq[$];
  int unsigned capt[$];

  xor_descrambler #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n && !clear && out_valid && out_ready) begin
      capq.push_back({24'd0, out_data});
      capt.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transmit-side reference: s = d ^ st[6] ^ st[5], st shifts in s.
  function automatic logic scr_step(input logic dbit);
    logic s;
    s  = dbit ^ st[6] ^ st[5];
    st = {st[5:0], s};
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the bit was accepted.
  task automatic send_bit(input logic b);
    int unsigned g;
    g = 0;
    in_valid = 1'b1;
    in_bit   = b;
    #1;
    while (!in_ready && g < 50) begin
      stalls++;
      g++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stalls = 0;
    capq.delete();
    capt.delete();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic lock_pattern(input string tag);
    int unsigned c0;
    out_ready = 1'b1;
    capq.delete();
    capt.delete();
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1);
      if (i == 5) check({tag, "_locked_early"}, {31'd0, locked}, 32'd0);
    end
    check({tag, "_locked"}, {31'd0, locked}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0);
      if (i == 6) check({tag, "_ov_early"}, {31'd0, out_valid}, 32'd0);
    end
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, out_data}, 32'h40);
    check({tag, "_latency"}, cyc - c0, 32'd15);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pulses"}, capq.size(), 32'd1);
    if (capq.size() > 0) check({tag, "_cap"}, capq[0], 32'h40);
  endtask

  initial begin : main
    logic [7:0] words [4];
    logic [7:0] w;
    logic       b;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    lock_pattern("lock");

    // Round trip through the reference scrambler.
    do_reset();
    st = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(scr_step(1'b0));
    for (int k = 0; k < 4; k++) begin
      w = words[k];
      for (int j = 0; j < 8; j++) send_bit(scr_step(w[j]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rt_stalls", stalls, 32'd0);
    check("rt_count", capq.size(), 32'd4);
    if (capq.size() == 4) begin
      for (int k = 0; k < 4; k++) check("rt_word", capq[k], {24'd0, words[k]});
      for (int k = 1; k < 4; k++) check("rt_spacing", capt[k] - capt[k-1], 32'd8);
    end

    // Backpressure across the 0xA5 / 0x3C boundary.
    do_reset();
    st = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(scr_step(1'b0));
    w = 8'hA5;
    for (int j = 0; j < 8; j++) send_bit(scr_step(w[j]));
    w = 8'h3C;
    for (int j = 0; j < 7; j++) send_bit(scr_step(w[j]));
    check("bp_no_early_stall", stalls, 32'd0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data", {24'd0, out_data}, 32'hA5);
    b = scr_step(w[7]);
    in_bit = b;
    in_valid = 1'b1;
    #1;
    check("bp_stall", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("bp_stable_data", {24'd0, out_data}, 32'hA5);
    check("bp_still_stalled", {31'd0, in_ready}, 32'd0);
    check("bp_no_take", capq.size(), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("sim_valid", {31'd0, out_valid}, 32'd1);
    check("sim_data", {24'd0, out_data}, 32'h3C);
    check("sim_first_take", capq.size(), 32'd1);
    if (capq.size() > 0) check("sim_first_word", capq[0], 32'hA5);
    @(negedge clk);
    check("bp_second_take", capq.size(), 32'd2);
    if (capq.size() > 1) check("bp_second_word", capq[1], 32'h3C);
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Clear mid-word while a finished word is being held.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    check("clr_pre_locked", {31'd0, locked}, 32'd1);
    check("clr_pre_stalls", stalls, 32'd0);
    clear = 1'b1;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_locked", {31'd0, locked}, 32'd0);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_out_data", {24'd0, out_data}, 32'h40);
    lock_pattern("clr_resync");

    // Asynchronous reset between clock edges during flush.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    in_valid = 1'b0;
    pulse_clear();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    in_valid = 1'b0;
    check("ar_pre_data", {24'd0, out_data}, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_out_data", {24'd0, out_data}, 32'd0);
    check("ar_locked", {31'd0, locked}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    lock_pattern("ar_relock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
